// File: rtl/multichannel_envelope_generator_if.sv
// Control and observation bundle for the multichannel envelope generator.
// Codes are packed 4 bits per channel; amplitudes AMP_BITS per channel.
interface multichannel_envelope_generator_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned AMP_BITS = 8
);
    logic [CHANNELS-1:0]          gate;
    logic [4*CHANNELS-1:0]        a;
    logic [4*CHANNELS-1:0]        d;
    logic [4*CHANNELS-1:0]        s;
    logic [4*CHANNELS-1:0]        r;
    logic [AMP_BITS*CHANNELS-1:0] amplitude;
    logic [CHANNELS-1:0]          active;
    logic [CHANNELS-1:0]          release_done;

    modport master (
        output gate, a, d, s, r,
        input  amplitude, active, release_done
    );

    modport slave (
        input  gate, a, d, s, r,
        output amplitude, active, release_done
    );
endinterface

// File: rtl/multichannel_envelope_generator.sv
// Multichannel ADSR envelope generator: one independent phase-accumulator FSM per channel,
// with per-code rate increments derived from CLK_FREQ at elaboration.
module multichannel_envelope_generator #(
    parameter int unsigned CLK_FREQ         = 1000000,
    parameter int unsigned ACCUMULATOR_BITS = 26,
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned AMP_BITS         = 8
) (
    input logic                              clk,
    input logic                              rst,
    multichannel_envelope_generator_if.slave bus
);
    localparam int unsigned AccW  = ACCUMULATOR_BITS + 1;
    localparam int unsigned ProdW = 2 * AMP_BITS;
    localparam int unsigned Shift = ACCUMULATOR_BITS - AMP_BITS;
    localparam logic [AMP_BITS-1:0] AmpMax = '1;

    function automatic longint unsigned attack_ms(input int unsigned code);
        case (code)
            0:       return 64'd2;
            1:       return 64'd8;
            2:       return 64'd16;
            3:       return 64'd24;
            4:       return 64'd38;
            5:       return 64'd56;
            6:       return 64'd68;
            7:       return 64'd80;
            8:       return 64'd100;
            9:       return 64'd250;
            10:      return 64'd500;
            11:      return 64'd800;
            12:      return 64'd1000;
            13:      return 64'd3000;
            14:      return 64'd5000;
            default: return 64'd8000;
        endcase
    endfunction

    // floor(2^ACC / (t * f)) with t in ms, clamped to [1, 2^ACC].
    function automatic logic [AccW-1:0] rate_inc(input int unsigned code,
                                                  input int unsigned mult);
        longint unsigned full;
        longint unsigned q;
        full = 64'd1 << ACCUMULATOR_BITS;
        q = (full * 64'd1000) / (attack_ms(code) * 64'(mult) * 64'(CLK_FREQ));
        if (q == 64'd0) q = 64'd1;
        if (q > full) q = full;
        return q[AccW-1:0];
    endfunction

    function automatic logic [16*AccW-1:0] rate_table(input int unsigned mult);
        logic [16*AccW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < 16; i++) t[i*AccW +: AccW] = rate_inc(i, mult);
        return t;
    endfunction

    localparam logic [16*AccW-1:0] AttackInc = rate_table(1);
    localparam logic [16*AccW-1:0] SlowInc   = rate_table(3);

    typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_e              state_q, state_d;
        logic [AccW-1:0]     acc_q, acc_d;
        logic [AMP_BITS-1:0] amp_q, amp_d;
        logic [AMP_BITS-1:0] rel_start_q, rel_start_d;
        logic [3:0]          a_q, a_d, d_q, d_d, s_q, s_d, r_q, r_d;
        logic                done_q, done_d;

        logic                gate_ch;
        logic [3:0]          a_in, d_in, s_in, r_in;
        logic [AccW-1:0]     inc, sum;
        logic                ovf;
        logic [AMP_BITS-1:0] frac, sustain, decay_drop, rel_drop;

        assign gate_ch = bus.gate[ch];
        assign a_in    = bus.a[4*ch +: 4];
        assign d_in    = bus.d[4*ch +: 4];
        assign s_in    = bus.s[4*ch +: 4];
        assign r_in    = bus.r[4*ch +: 4];

        always_comb begin
            inc = '0;
            unique case (state_q)
                StAttack:  inc = AttackInc[32'(a_q) * AccW +: AccW];
                StDecay:   inc = SlowInc[32'(d_q) * AccW +: AccW];
                StRelease: inc = SlowInc[32'(r_q) * AccW +: AccW];
                default:   inc = '0;
            endcase
        end

        assign sum        = acc_q + inc;
        assign ovf        = sum[AccW-1];
        assign frac       = sum[ACCUMULATOR_BITS-1 -: AMP_BITS];
        assign sustain    = {(AMP_BITS/4){s_q}};
        assign decay_drop = AMP_BITS'((ProdW'(AmpMax - sustain) * ProdW'(frac)) >> AMP_BITS);
        assign rel_drop   = AMP_BITS'((ProdW'(rel_start_q) * ProdW'(frac)) >> AMP_BITS);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= StIdle;
                acc_q       <= '0;
                amp_q       <= '0;
                rel_start_q <= '0;
                a_q         <= '0;
                d_q         <= '0;
                s_q         <= '0;
                r_q         <= '0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                acc_q       <= acc_d;
                amp_q       <= amp_d;
                rel_start_q <= rel_start_d;
                a_q         <= a_d;
                d_q         <= d_d;
                s_q         <= s_d;
                r_q         <= r_d;
                done_q      <= done_d;
            end
        end

        // Gate changes always win over accumulator overflow in the same cycle.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StIdle:    if (gate_ch) state_d = StAttack;
                StAttack:  if (!gate_ch) state_d = StRelease; else if (ovf) state_d = StDecay;
                StDecay:   if (!gate_ch) state_d = StRelease; else if (ovf) state_d = StSustain;
                StSustain: if (!gate_ch) state_d = StRelease;
                StRelease: if (gate_ch) state_d = StAttack; else if (ovf) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end

        always_comb begin
            acc_d       = acc_q;
            amp_d       = amp_q;
            rel_start_d = rel_start_q;
            a_d         = a_q;
            d_d         = d_q;
            s_d         = s_q;
            r_d         = r_q;
            done_d      = 1'b0;
            if ((state_q == StIdle || state_q == StRelease) && gate_ch) begin
                a_d = a_in;
                d_d = d_in;
                s_d = s_in;
            end
            unique case (state_q)
                StIdle: begin
                    acc_d = '0;
                    amp_d = '0;
                end
                StAttack, StDecay, StSustain: begin
                    if (!gate_ch) begin
                        acc_d       = '0;
                        rel_start_d = amp_q;
                        r_d         = r_in;
                    end else if (state_q == StSustain || ovf) begin
                        acc_d = '0;
                        amp_d = (state_q == StAttack) ? AmpMax : sustain;
                    end else begin
                        acc_d = sum;
                        amp_d = (state_q == StAttack) ? frac : AmpMax - decay_drop;
                    end
                end
                StRelease: begin
                    // Legato retrigger: resume the attack ramp from the current level.
                    if (gate_ch) begin
                        acc_d = AccW'(amp_q) << Shift;
                    end else if (ovf) begin
                        acc_d  = '0;
                        amp_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        acc_d = sum;
                        amp_d = rel_start_q - rel_drop;
                    end
                end
                default: begin
                    acc_d = '0;
                    amp_d = '0;
                end
            endcase
        end

        assign bus.amplitude[AMP_BITS*ch +: AMP_BITS] = amp_q;
        assign bus.active[ch]                         = (state_q != StIdle);
        assign bus.release_done[ch]                   = done_q;
    end
endmodule

// File: tb/tb_multichannel_envelope_generator.sv
// Bench for the envelope generator: two configurations, directed scenarios plus random gating,
// every cycle scored against an arithmetic per-voice reference model.
module tb_multichannel_envelope_generator;
    localparam int unsigned CH0 = 4, AMP0 = 8, ACC0 = 26, F0 = 1000000;
    localparam int unsigned CH1 = 2, AMP1 = 12, ACC1 = 20, F1 = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multichannel_envelope_generator_if #(.CHANNELS(CH0), .AMP_BITS(AMP0)) bus0 ();
    multichannel_envelope_generator_if #(.CHANNELS(CH1), .AMP_BITS(AMP1)) bus1 ();

    multichannel_envelope_generator #(
        .CLK_FREQ(F0), .ACCUMULATOR_BITS(ACC0), .CHANNELS(CH0), .AMP_BITS(AMP0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    multichannel_envelope_generator #(
        .CLK_FREQ(F1), .ACCUMULATOR_BITS(ACC1), .CHANNELS(CH1), .AMP_BITS(AMP1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int ms_tab [16] = '{2, 8, 16, 24, 38, 56, 68, 80, 100, 250, 500, 800, 1000, 3000, 5000, 8000};

    // phase: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    typedef struct {
        int     phase;
        longint pos;
        longint level;
        longint start;
        int     la, ld, ls, lr;
        bit     done;
    } voice_t;

    voice_t m0 [CH0];
    voice_t m1 [CH1];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    function automatic voice_t idle_voice();
        voice_t v;
        v.phase = 0; v.pos = 0; v.level = 0; v.start = 0;
        v.la = 0; v.ld = 0; v.ls = 0; v.lr = 0; v.done = 1'b0;
        return v;
    endfunction

    function automatic longint rate(input int code, input int mult, input int xb, input int hz);
        longint q;
        q = ((longint'(1) << xb) * 1000) / (longint'(ms_tab[code]) * mult * hz);
        return (q < 1) ? 1 : q;
    endfunction

    function automatic voice_t step(input voice_t vin, input bit g, input int ca, input int cd,
                                    input int cs, input int cr, input int ab, input int xb,
                                    input int hz);
        voice_t v;
        longint full, top, sus, nxt, f;
        v    = vin;
        full = longint'(1) << xb;
        top  = (longint'(1) << ab) - 1;
        sus  = longint'(v.ls) * (top / 15);
        v.done = 1'b0;
        if (v.phase == 0) begin
            v.level = 0; v.pos = 0;
            if (g) begin v.phase = 1; v.la = ca; v.ld = cd; v.ls = cs; end
        end else if (v.phase == 4) begin
            if (g) begin
                v.phase = 1; v.pos = v.level << (xb - ab);
                v.la = ca; v.ld = cd; v.ls = cs;
            end else begin
                nxt = v.pos + rate(v.lr, 3, xb, hz);
                if (nxt >= full) begin
                    v.phase = 0; v.level = 0; v.pos = 0; v.done = 1'b1;
                end else begin
                    f = nxt >> (xb - ab);
                    v.pos = nxt;
                    v.level = v.start - ((v.start * f) >> ab);
                end
            end
        end else if (!g) begin
            v.phase = 4; v.start = v.level; v.pos = 0; v.lr = cr;
        end else if (v.phase == 1) begin
            nxt = v.pos + rate(v.la, 1, xb, hz);
            if (nxt >= full) begin v.level = top; v.pos = 0; v.phase = 2; end
            else begin v.pos = nxt; v.level = nxt >> (xb - ab); end
        end else if (v.phase == 2) begin
            nxt = v.pos + rate(v.ld, 3, xb, hz);
            if (nxt >= full) begin v.level = sus; v.pos = 0; v.phase = 3; end
            else begin
                f = nxt >> (xb - ab);
                v.pos = nxt;
                v.level = top - (((top - sus) * f) >> ab);
            end
        end else begin
            v.level = sus; v.pos = 0;
        end
        return v;
    endfunction

    // Advance both models on the current inputs, queue expectations, then let the edge happen.
    task automatic tick();
        logic [63:0] e0, e1;
        longint lv;
        e0 = '0;
        e1 = '0;
        for (int c = 0; c < CH0; c++) begin
            if (rst) m0[c] = idle_voice();
            else m0[c] = step(m0[c], bus0.gate[c], int'(bus0.a[4*c +: 4]), int'(bus0.d[4*c +: 4]),
                              int'(bus0.s[4*c +: 4]), int'(bus0.r[4*c +: 4]), AMP0, ACC0, F0);
            lv = m0[c].level;
            e0[2*CH0 + AMP0*c +: AMP0] = lv[AMP0-1:0];
            e0[CH0 + c] = (m0[c].phase != 0);
            e0[c] = m0[c].done;
        end
        for (int c = 0; c < CH1; c++) begin
            if (rst) m1[c] = idle_voice();
            else m1[c] = step(m1[c], bus1.gate[c], int'(bus1.a[4*c +: 4]), int'(bus1.d[4*c +: 4]),
                              int'(bus1.s[4*c +: 4]), int'(bus1.r[4*c +: 4]), AMP1, ACC1, F1);
            lv = m1[c].level;
            e1[2*CH1 + AMP1*c +: AMP1] = lv[AMP1-1:0];
            e1[CH1 + c] = (m1[c].phase != 0);
            e1[c] = m1[c].done;
        end
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check($sformatf("dut0 outputs cycle %0d", cyc),
                      64'({bus0.amplitude, bus0.active, bus0.release_done}), e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check($sformatf("dut1 outputs cycle %0d", cyc),
                      64'({bus1.amplitude, bus1.active, bus1.release_done}), e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int amp0(input int c);
        return int'(bus0.amplitude[AMP0*c +: AMP0]);
    endfunction

    function automatic int amp1(input int c);
        return int'(bus1.amplitude[AMP1*c +: AMP1]);
    endfunction

    task automatic codes0(input int c, input int ca, input int cd, input int cs, input int cr);
        bus0.a[4*c +: 4] = 4'(ca); bus0.d[4*c +: 4] = 4'(cd);
        bus0.s[4*c +: 4] = 4'(cs); bus0.r[4*c +: 4] = 4'(cr);
    endtask

    initial begin
        int k, viol, prev, dones, act_at, amp_at;
        bus0.gate = '0; bus0.a = '0; bus0.d = '0; bus0.s = '0; bus0.r = '0;
        bus1.gate = '0; bus1.a = '0; bus1.d = '0; bus1.s = '0; bus1.r = '0;
        for (int c = 0; c < CH0; c++) m0[c] = idle_voice();
        for (int c = 0; c < CH1; c++) m1[c] = idle_voice();

        rst = 1'b1;
        tick();
        tick();
        check("reset amplitude dut0", 64'(bus0.amplitude), 64'd0);
        check("reset active dut0", 64'(bus0.active), 64'd0);
        check("reset amplitude dut1", 64'(bus1.amplitude), 64'd0);
        check("reset active dut1", 64'(bus1.active), 64'd0);
        rst = 1'b0;

        // ch0: fastest attack into decay toward sustain 136; dut1 ch0 toward 4095.
        codes0(0, 0, 0, 8, 0);
        bus0.gate[0] = 1'b1;
        bus1.a = '0; bus1.d = '0; bus1.s = 8'h0f; bus1.r = '0;
        bus1.gate[0] = 1'b1;
        tick();
        check("ch0 active after gate", 64'(bus0.active[0]), 64'd1);
        check("ch0 amplitude on attack entry", 64'(amp0(0)), 64'd0);
        repeat (1992) tick();
        check("ch0 attack cycle 1992", 64'(amp0(0)), 64'd254);
        tick();
        check("ch0 attack cycle 1993", 64'(amp0(0)), 64'd255);
        repeat (8) tick();
        viol = 0; prev = amp0(0);
        repeat (6000) begin
            tick();
            if (amp0(0) > prev) viol++;
            prev = amp0(0);
        end
        check("ch0 decay monotonic", 64'(viol), 64'd0);
        check("ch0 last decay step", 64'(amp0(0)), 64'd137);
        tick();
        check("ch0 reaches sustain", 64'(amp0(0)), 64'd136);
        viol = 0;
        repeat (50) begin
            tick();
            if (amp0(0) != 136 || !bus0.active[0]) viol++;
        end
        check("ch0 sustain holds", 64'(viol), 64'd0);

        // ch1: gate drops mid-attack at 100, release to 0.
        codes0(1, 0, 0, 0, 0);
        bus0.gate[1] = 1'b1;
        tick();
        k = 0;
        while (amp0(1) < 100 && k < 3000) begin tick(); k++; end
        check("ch1 attack reaches 100", 64'(amp0(1)), 64'd100);
        bus0.gate[1] = 1'b0;
        tick();
        check("ch1 release entry holds level", 64'(amp0(1)), 64'd100);
        viol = 0; prev = 100; dones = 0; act_at = 1; amp_at = 1;
        for (k = 0; k < 7000 && bus0.active[1]; k++) begin
            tick();
            if (amp0(1) > prev) viol++;
            prev = amp0(1);
            if (bus0.release_done[1]) begin
                dones++; act_at = int'(bus0.active[1]); amp_at = amp0(1);
            end
        end
        repeat (5) begin
            tick();
            if (bus0.release_done[1]) dones++;
        end
        check("ch1 release monotonic", 64'(viol), 64'd0);
        check("ch1 release_done pulses", 64'(dones), 64'd1);
        check("ch1 active at release_done", 64'(act_at), 64'd0);
        check("ch1 amplitude at release_done", 64'(amp_at), 64'd0);

        // ch2: legato retrigger at 60 with codes changed mid-release.
        codes0(2, 0, 0, 15, 0);
        bus0.gate[2] = 1'b1;
        tick();
        k = 0;
        while (amp0(2) < 200 && k < 3000) begin tick(); k++; end
        bus0.gate[2] = 1'b0;
        tick();
        codes0(2, 1, 2, 4, 5);
        k = 0;
        while (amp0(2) > 60 && k < 7000) begin tick(); k++; end
        check("ch2 release reaches 60", 64'(amp0(2)), 64'd60);
        bus0.gate[2] = 1'b1;
        tick();
        check("ch2 retrigger no step", 64'(amp0(2)), 64'd60);
        viol = 0; prev = 60;
        repeat (300) begin
            tick();
            if (amp0(2) < prev) viol++;
            prev = amp0(2);
        end
        check("ch2 attack monotonic", 64'(viol), 64'd0);
        check("ch2 attack uses new code", 64'(amp0(2)), 64'd69);

        // ch3 and dut1 ch1 mid-decay when reset hits with gates held.
        codes0(3, 0, 0, 0, 0);
        bus0.gate[3] = 1'b1;
        tick();
        repeat (4601) tick();
        bus1.gate[1] = 1'b1;
        repeat (400) tick();
        check("ch3 mid decay level", 64'(amp0(3)), 64'd129);
        check("dut1 ch0 sustain at max", 64'(amp1(0)), 64'd4095);
        check("dut1 ch1 active before reset", 64'(bus1.active[1]), 64'd1);
        rst = 1'b1;
        tick();
        check("mid reset amplitude dut0", 64'(bus0.amplitude), 64'd0);
        check("mid reset active dut0", 64'(bus0.active), 64'd0);
        check("mid reset release_done dut0", 64'(bus0.release_done), 64'd0);
        check("mid reset amplitude dut1", 64'(bus1.amplitude), 64'd0);
        rst = 1'b0;
        tick();
        check("post reset active dut0", 64'(bus0.active), 64'b1101);
        check("post reset active dut1", 64'(bus1.active), 64'b11);
        check("post reset amplitude dut0", 64'(bus0.amplitude), 64'd0);
        repeat (201) tick();
        check("dut1 ch0 max after restart", 64'(amp1(0)), 64'd4095);

        // Random gating and codes on every channel of both configurations.
        repeat (6000) begin
            for (int c = 0; c < CH0; c++)
                if ($urandom_range(0, 299) == 0) bus0.gate[c] = ~bus0.gate[c];
            for (int c = 0; c < CH1; c++)
                if ($urandom_range(0, 149) == 0) bus1.gate[c] = ~bus1.gate[c];
            bus0.a = 16'($urandom()) & 16'h1111;
            bus0.d = 16'($urandom()) & 16'h1111;
            bus0.s = 16'($urandom());
            bus0.r = 16'($urandom()) & 16'h1111;
            bus1.a = 8'($urandom()) & 8'h33;
            bus1.d = 8'($urandom()) & 8'h33;
            bus1.s = 8'($urandom());
            bus1.r = 8'($urandom()) & 8'h33;
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
        check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
